// File: rtl/cv32e40p_x_disp_mo.sv
// Multi-outstanding x-interface dispatcher for the ID stage.
// Offloads decoder-rejected instructions to the coprocessor and tags each
// accepted instruction with an ID. Per-register pending-write counters let
// several writes to the same rd be in flight. Returning results are matched
// by ID, and the block supplies the destination register for write-back.
module cv32e40p_x_disp_mo #(
    parameter int NUM_RS          = 3,
    parameter int ID_WIDTH        = 3,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  x_illegal_insn_dec_i,
    input  logic                  x_branch_or_jump_i,
    input  logic [NUM_RS*5-1:0]   x_rs_addr_i,
    input  logic [NUM_RS-1:0]     x_regs_used_i,
    input  logic [4:0]            x_waddr_id_i,
    input  logic                  x_writeback_i,
    input  logic [4:0]            x_waddr_ex_i,
    input  logic                  x_we_ex_i,
    input  logic [4:0]            x_waddr_wb_i,
    input  logic                  x_we_wb_i,
    input  logic                  x_is_mem_op_i,
    output logic                  x_valid_o,
    input  logic                  x_ready_i,
    input  logic                  x_accept_i,
    output logic [ID_WIDTH-1:0]   x_id_o,
    output logic [NUM_RS-1:0]     x_rs_valid_o,
    output logic                  x_rd_clean_o,
    output logic                  x_stall_o,
    output logic                  x_illegal_insn_o,
    input  logic                  x_rvalid_i,
    output logic                  x_rready_o,
    input  logic [ID_WIDTH-1:0]   x_rid_i,
    input  logic                  x_rwe_i,
    output logic [4:0]            x_rwaddr_o,
    output logic                  x_rwe_o,
    output logic                  x_rid_err_o,
    output logic [CW-1:0]         x_outstanding_o,
    output logic                  x_idle_o
);

    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0]       MAX_CNT  = CW'(MAX_OUTSTANDING);

    // Per-slot tracking, indexed by instruction ID
    logic        busy_q [MAX_OUTSTANDING];
    logic [4:0]  rd_q   [MAX_OUTSTANDING];
    logic        we_q   [MAX_OUTSTANDING];

    logic [CW-1:0]       cnt_q [31:1];
    logic [31:0]         pend;
    logic [CW-1:0]       outst_q;
    logic [ID_WIDTH-1:0] next_id_q;

    logic                busy_next_slot;
    logic                hit;
    logic [4:0]          hit_rd;
    logic                hit_we;
    logic                full;
    logic                cand;
    logic                fire;
    logic                issue;
    logic                issue_we;
    logic                res;
    logic                res_we;
    logic [NUM_RS-1:0]   dep_vec;

    // Look up the slot the next issue would use and the slot addressed by the result
    always_comb begin
        busy_next_slot = 1'b0;
        hit            = 1'b0;
        hit_rd         = 5'd0;
        hit_we         = 1'b0;
        for (int s = 0; s < MAX_OUTSTANDING; s++) begin
            if (next_id_q == ID_WIDTH'(s)) begin
                busy_next_slot = busy_q[s];
            end
            if ((x_rid_i == ID_WIDTH'(s)) && busy_q[s]) begin
                hit    = 1'b1;
                hit_rd = rd_q[s];
                hit_we = we_q[s];
            end
        end
    end

    assign full     = (outst_q == MAX_CNT) | busy_next_slot;
    assign cand     = x_illegal_insn_dec_i & ~x_branch_or_jump_i;
    assign fire     = x_valid_o & x_ready_i;
    assign issue    = fire & x_accept_i;
    assign issue_we = x_writeback_i & (x_waddr_id_i != 5'd0);
    assign res      = x_rvalid_i & hit;
    assign res_we   = res & hit_we;

    assign x_valid_o        = cand & ~full;
    assign x_id_o           = next_id_q;
    assign x_illegal_insn_o = fire & ~x_accept_i;
    assign x_rready_o       = 1'b1;
    assign x_rwaddr_o       = hit ? hit_rd : 5'd0;
    assign x_rwe_o          = res_we & x_rwe_i;
    assign x_rid_err_o      = x_rvalid_i & ~hit;
    assign x_outstanding_o  = outst_q;
    assign x_idle_o         = (outst_q == '0);

    // x0 never has a pending write
    assign pend[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc      = issue & issue_we & (x_waddr_id_i == 5'(gi));
            assign dec      = res_we & (hit_rd == 5'(gi));
            assign pend[gi] = (cnt_q[gi] != '0);

            // Pending-write counter for register gi; issue and result may coincide
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_q[gi] + CW'(inc) - CW'(dec);
                end
            end

            a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                dec |-> (cnt_q[gi] != '0));
        end

        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
            // Slot gi is claimed by an accepted issue and released by its result
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    busy_q[gi] <= 1'b0;
                    rd_q[gi]   <= 5'd0;
                    we_q[gi]   <= 1'b0;
                end else if (issue && (next_id_q == ID_WIDTH'(gi))) begin
                    busy_q[gi] <= 1'b1;
                    rd_q[gi]   <= x_waddr_id_i;
                    we_q[gi]   <= issue_we;
                end else if (res && (x_rid_i == ID_WIDTH'(gi))) begin
                    busy_q[gi] <= 1'b0;
                end
            end
        end

        for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
            logic [4:0] rs;
            assign rs = x_rs_addr_i[gi*5 +: 5];
            assign x_rs_valid_o[gi] = (rs == 5'd0) |
                ~(pend[rs] | ((rs == x_waddr_ex_i) & x_we_ex_i) | ((rs == x_waddr_wb_i) & x_we_wb_i));
            assign dep_vec[gi] = x_regs_used_i[gi] & (rs != 5'd0) & pend[rs];
        end
    endgenerate

    assign x_rd_clean_o = (x_waddr_id_i == 5'd0) |
        ~(pend[x_waddr_id_i] | ((x_waddr_id_i == x_waddr_ex_i) & x_we_ex_i) |
          ((x_waddr_id_i == x_waddr_wb_i) & x_we_wb_i));

    assign x_stall_o = (x_valid_o & ~x_ready_i) | (cand & full) | (|dep_vec) | x_is_mem_op_i;

    // In-flight count and ID allocation pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_q   <= '0;
            next_id_q <= '0;
        end else begin
            outst_q <= outst_q + CW'(issue) - CW'(res);
            if (issue) begin
                next_id_q <= (next_id_q == LAST_ID) ? '0 : next_id_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_disp_mo.sv
// Self-checking bench for cv32e40p_x_disp_mo: directed scenarios plus random
// traffic compared against a slot-list reference model.
module tb_cv32e40p_x_disp_mo;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_c, bj, wb, weex, wewb, mem, ready, accept, rvalid, rwe;
    logic [14:0] rs_a;
    logic [2:0]  used;
    logic [4:0]  waddr_id, wex, wwb;
    logic [2:0]  rid;

    logic        valid, rd_clean, stall, illegal, rready, rwe_o, rid_err, idle;
    logic [2:0]  id, rs_valid, outst;
    logic [4:0]  rwaddr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of in-flight slots
    bit m_busy [M];
    int m_rd   [M];
    bit m_we   [M];
    int m_next;

    always #5 clk = ~clk;

    cv32e40p_x_disp_mo #(.NUM_RS(3), .ID_WIDTH(3), .MAX_OUTSTANDING(M)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_illegal_insn_dec_i(dec_c), .x_branch_or_jump_i(bj),
        .x_rs_addr_i(rs_a), .x_regs_used_i(used),
        .x_waddr_id_i(waddr_id), .x_writeback_i(wb),
        .x_waddr_ex_i(wex), .x_we_ex_i(weex),
        .x_waddr_wb_i(wwb), .x_we_wb_i(wewb),
        .x_is_mem_op_i(mem),
        .x_valid_o(valid), .x_ready_i(ready), .x_accept_i(accept),
        .x_id_o(id), .x_rs_valid_o(rs_valid), .x_rd_clean_o(rd_clean),
        .x_stall_o(stall), .x_illegal_insn_o(illegal),
        .x_rvalid_i(rvalid), .x_rready_o(rready), .x_rid_i(rid), .x_rwe_i(rwe),
        .x_rwaddr_o(rwaddr), .x_rwe_o(rwe_o), .x_rid_err_o(rid_err),
        .x_outstanding_o(outst), .x_idle_o(idle)
    );

    function automatic int m_outst();
        int n = 0;
        for (int k = 0; k < M; k++) if (m_busy[k]) n++;
        return n;
    endfunction

    function automatic int m_pend(int r);
        int n = 0;
        if (r == 0) return 0;
        for (int k = 0; k < M; k++) if (m_busy[k] && m_we[k] && m_rd[k] == r) n++;
        return n;
    endfunction

    function automatic bit m_full();
        return (m_outst() == M) || m_busy[m_next];
    endfunction

    function automatic bit m_cand();
        return dec_c && !bj;
    endfunction

    function automatic bit e_valid();
        return m_cand() && !m_full();
    endfunction

    function automatic bit m_haz(int r);
        return (r != 0) && ((m_pend(r) > 0) || (r == int'(wex) && weex) || (r == int'(wwb) && wewb));
    endfunction

    function automatic logic [2:0] e_rs_valid();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = !m_haz(int'(rs_a[i*5 +: 5]));
        return v;
    endfunction

    function automatic bit e_dep();
        bit d = 0;
        for (int i = 0; i < 3; i++)
            if (used[i] && m_pend(int'(rs_a[i*5 +: 5])) > 0) d = 1;
        return d;
    endfunction

    function automatic bit e_stall();
        return (e_valid() && !ready) || (m_cand() && m_full()) || e_dep() || mem;
    endfunction

    function automatic bit e_hit();
        return rvalid && (int'(rid) < M) && m_busy[rid];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < M; k++) begin
            m_busy[k] = 0; m_rd[k] = 0; m_we[k] = 0;
        end
        m_next = 0;
    endtask

    // Advance the model across one clock edge using the inputs held at that edge
    task automatic model_update();
        bit hit, fire;
        if (rst) begin
            model_reset();
            return;
        end
        hit  = e_hit();
        fire = e_valid() && ready;
        if (hit) begin
            $display("txn result id=%0d rd=%0d we=%0d", rid, m_rd[rid], m_we[rid]);
            m_busy[rid] = 0;
        end else if (rvalid) begin
            $display("txn result id=%0d not outstanding", rid);
        end
        if (fire && accept) begin
            $display("txn issue id=%0d rd=%0d wb=%0d", m_next, waddr_id, wb);
            m_busy[m_next] = 1;
            m_rd[m_next]   = int'(waddr_id);
            m_we[m_next]   = wb && (waddr_id != 0);
            m_next         = (m_next + 1) % M;
        end else if (fire) begin
            $display("txn issue rejected rd=%0d", waddr_id);
        end
    endtask

    task automatic idle_in();
        dec_c = 0; bj = 0; wb = 0; weex = 0; wewb = 0; mem = 0; ready = 0; accept = 0;
        rvalid = 0; rwe = 0; rs_a = '0; used = '0; waddr_id = '0; wex = '0; wwb = '0; rid = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic apply_reset();
        rst = 1; idle_in();
        cycle();
        rst = 0;
    endtask

    task automatic issue_rd(int r);
        idle_in(); dec_c = 1; waddr_id = 5'(r); wb = 1; ready = 1; accept = 1;
        cycle();
        idle_in();
    endtask

    task automatic drain();
        for (int k = 0; k < M; k++) begin
            if (m_busy[k]) begin
                idle_in(); rvalid = 1; rid = 3'(k); rwe = 1;
                cycle();
            end
        end
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        settle();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_checks++; if (outst !== 3'd0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", outst); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (rid_err !== 1'b0) begin n_fail++; $display("FAIL reset_rid_err: got %b want 0", rid_err); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready: got %b want 1", rready); end
        dec_c = 1;
        #1;
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL reset_cand_valid: got %b want 1", valid); end
        cycle();
        rst = 0; model_reset(); idle_in();
    endtask

    task automatic test_basic();
        idle_in(); dec_c = 1; waddr_id = 5; wb = 1; ready = 1; accept = 1; rs_a[4:0] = 5;
        settle();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid); end
        n_checks++; if (id !== 3'd0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", id); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall: got %b want 0", stall); end
        cycle();
        idle_in(); rs_a[4:0] = 5; waddr_id = 5;
        settle();
        n_checks++; if (outst !== 3'd1) begin n_fail++; $display("FAIL basic_outst: got %0d want 1", outst); end
        n_checks++; if (rs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_rs_pending: got %b want 0", rs_valid[0]); end
        n_checks++; if (rd_clean !== 1'b0) begin n_fail++; $display("FAIL basic_rd_clean: got %b want 0", rd_clean); end
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", idle); end
        rvalid = 1; rid = 0; rwe = 1;
        settle();
        n_checks++; if (rwaddr !== 5'd5) begin n_fail++; $display("FAIL basic_rwaddr: got %0d want 5", rwaddr); end
        n_checks++; if (rwe_o !== 1'b1) begin n_fail++; $display("FAIL basic_rwe: got %b want 1", rwe_o); end
        cycle();
        idle_in(); rs_a[4:0] = 5;
        settle();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b want 1", idle); end
        n_checks++; if (rs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_rs_clear: got %b want 1", rs_valid[0]); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int k = 0; k < M; k++) begin
            idle_in(); dec_c = 1; waddr_id = 5'(10 + k); wb = 1; ready = 1; accept = 1;
            settle();
            n_checks++; if (id !== 3'(k)) begin n_fail++; $display("FAIL full_issue_id: got %0d want %0d", id, k); end
            cycle();
        end
        idle_in(); dec_c = 1; waddr_id = 20; wb = 1; ready = 1; accept = 1;
        settle();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_valid: got %b want 0", valid); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", stall); end
        rvalid = 1; rid = 2; rwe = 1;
        settle();
        n_checks++; if (rwaddr !== 5'd12) begin n_fail++; $display("FAIL full_rwaddr2: got %0d want 12", rwaddr); end
        cycle();
        rvalid = 0;
        settle();
        n_checks++; if (outst !== 3'd3) begin n_fail++; $display("FAIL full_outst3: got %0d want 3", outst); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_id0_busy_valid: got %b want 0", valid); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_id0_busy_stall: got %b want 1", stall); end
        rvalid = 1; rid = 0;
        settle();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_reuse: got %b want 0", valid); end
        cycle();
        rvalid = 0;
        settle();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL full_fifth_valid: got %b want 1", valid); end
        n_checks++; if (id !== 3'd0) begin n_fail++; $display("FAIL full_fifth_id: got %0d want 0", id); end
        cycle();
        idle_in();
        settle();
        n_checks++; if (outst !== 3'd3) begin n_fail++; $display("FAIL full_after: got %0d want 3", outst); end
        drain();
    endtask

    task automatic test_out_of_order();
        apply_reset();
        issue_rd(7);
        issue_rd(7);
        rs_a[4:0] = 7; waddr_id = 7;
        settle();
        n_checks++; if (rs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ooo_rs_two: got %b want 0", rs_valid[0]); end
        rvalid = 1; rid = 1; rwe = 1;
        settle();
        n_checks++; if (rwaddr !== 5'd7) begin n_fail++; $display("FAIL ooo_rwaddr1: got %0d want 7", rwaddr); end
        cycle();
        rvalid = 0;
        settle();
        n_checks++; if (rs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ooo_rs_one: got %b want 0", rs_valid[0]); end
        n_checks++; if (rd_clean !== 1'b0) begin n_fail++; $display("FAIL ooo_rd_one: got %b want 0", rd_clean); end
        rvalid = 1; rid = 0;
        cycle();
        rvalid = 0;
        settle();
        n_checks++; if (rs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ooo_rs_zero: got %b want 1", rs_valid[0]); end
        n_checks++; if (rd_clean !== 1'b1) begin n_fail++; $display("FAIL ooo_rd_zero: got %b want 1", rd_clean); end
        idle_in();
    endtask

    task automatic test_reject();
        int exp_outst, exp_id;
        issue_rd(2);
        idle_in(); dec_c = 1; waddr_id = 9; wb = 1; ready = 1; accept = 0;
        settle();
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL reject_illegal: got %b want 1", illegal); end
        exp_outst = m_outst(); exp_id = m_next;
        cycle();
        idle_in();
        settle();
        n_checks++; if (int'(outst) !== exp_outst) begin n_fail++; $display("FAIL reject_outst: got %0d want %0d", outst, exp_outst); end
        n_checks++; if (int'(id) !== exp_id) begin n_fail++; $display("FAIL reject_id: got %0d want %0d", id, exp_id); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reject_illegal_clr: got %b want 0", illegal); end
        drain();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        issue_rd(3);
        dec_c = 1; waddr_id = 3; wb = 1; ready = 1; accept = 1;
        rvalid = 1; rid = 0; rwe = 1;
        settle();
        n_checks++; if (rwaddr !== 5'd3) begin n_fail++; $display("FAIL simul_rwaddr: got %0d want 3", rwaddr); end
        n_checks++; if (id !== 3'd1) begin n_fail++; $display("FAIL simul_id: got %0d want 1", id); end
        cycle();
        idle_in(); rs_a[4:0] = 3;
        settle();
        n_checks++; if (outst !== 3'd1) begin n_fail++; $display("FAIL simul_outst: got %0d want 1", outst); end
        n_checks++; if (rs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL simul_rs: got %b want 0", rs_valid[0]); end
        rvalid = 1; rid = 1; rwe = 1;
        cycle();
        rvalid = 0;
        settle();
        n_checks++; if (rs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL simul_rs_clear: got %b want 1", rs_valid[0]); end
        idle_in();
    endtask

    task automatic test_rid_err_x0();
        apply_reset();
        rvalid = 1; rid = 3; rwe = 1;
        settle();
        n_checks++; if (rid_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", rid_err); end
        n_checks++; if (rwe_o !== 1'b0) begin n_fail++; $display("FAIL err_rwe: got %b want 0", rwe_o); end
        cycle();
        idle_in();
        settle();
        n_checks++; if (outst !== 3'd0) begin n_fail++; $display("FAIL err_outst: got %0d want 0", outst); end
        issue_rd(0);
        used = 3'b001; waddr_id = 0;
        settle();
        n_checks++; if (rs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL x0_rs_valid: got %b want 1", rs_valid[0]); end
        n_checks++; if (rd_clean !== 1'b1) begin n_fail++; $display("FAIL x0_rd_clean: got %b want 1", rd_clean); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall); end
        n_checks++; if (outst !== 3'd1) begin n_fail++; $display("FAIL x0_outst: got %0d want 1", outst); end
        rvalid = 1; rid = 0; rwe = 1;
        settle();
        n_checks++; if (rwe_o !== 1'b0) begin n_fail++; $display("FAIL x0_rwe: got %b want 0", rwe_o); end
        n_checks++; if (rid_err !== 1'b0) begin n_fail++; $display("FAIL x0_rid_err: got %b want 0", rid_err); end
        cycle();
        idle_in();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        issue_rd(4);
        issue_rd(6);
        #1 rst = 1;
        #1;
        n_checks++; if (outst !== 3'd0) begin n_fail++; $display("FAIL midrst_outst: got %0d want 0", outst); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b want 1", idle); end
        cycle();
        rst = 0;
        rvalid = 1; rid = 0; rwe = 1;
        settle();
        n_checks++; if (rid_err !== 1'b1) begin n_fail++; $display("FAIL midrst_rid_err: got %b want 1", rid_err); end
        cycle();
        idle_in();
    endtask

    task automatic test_random();
        logic [2:0] ev;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            dec_c = ($urandom_range(0, 9) < 6); bj = ($urandom_range(0, 9) == 0);
            waddr_id = 5'($urandom_range(0, 7)); wb = 1'($urandom);
            ready = ($urandom_range(0, 9) < 8); accept = ($urandom_range(0, 9) < 8);
            mem = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 3; i++) rs_a[i*5 +: 5] = 5'($urandom_range(0, 7));
            used = 3'($urandom);
            wex = 5'($urandom_range(0, 7)); weex = ($urandom_range(0, 3) == 0);
            wwb = 5'($urandom_range(0, 7)); wewb = ($urandom_range(0, 3) == 0);
            rvalid = 1'($urandom); rwe = 1'($urandom);
            rid = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, M - 1));
            settle();
            ev = e_rs_valid();
            n_checks++; if (valid !== e_valid()) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, valid, e_valid()); end
            n_checks++; if (int'(id) !== m_next) begin n_fail++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, id, m_next); end
            n_checks++; if (stall !== e_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall, e_stall()); end
            n_checks++; if (rs_valid !== ev) begin n_fail++; $display("FAIL rnd_rs_valid c=%0d: got %b want %b", c, rs_valid, ev); end
            n_checks++; if (rd_clean !== !m_haz(int'(waddr_id))) begin n_fail++; $display("FAIL rnd_rd_clean c=%0d: got %b want %b", c, rd_clean, !m_haz(int'(waddr_id))); end
            n_checks++; if (illegal !== (e_valid() && ready && !accept)) begin n_fail++; $display("FAIL rnd_illegal c=%0d: got %b", c, illegal); end
            n_checks++; if (rid_err !== (rvalid && !e_hit())) begin n_fail++; $display("FAIL rnd_rid_err c=%0d: got %b want %b", c, rid_err, rvalid && !e_hit()); end
            n_checks++; if (rwe_o !== (e_hit() && m_we[rid] && rwe)) begin n_fail++; $display("FAIL rnd_rwe c=%0d: got %b", c, rwe_o); end
            if (e_hit()) begin
                n_checks++; if (int'(rwaddr) !== m_rd[rid]) begin n_fail++; $display("FAIL rnd_rwaddr c=%0d: got %0d want %0d", c, rwaddr, m_rd[rid]); end
            end
            n_checks++; if (int'(outst) !== m_outst()) begin n_fail++; $display("FAIL rnd_outst c=%0d: got %0d want %0d", c, outst, m_outst()); end
            n_checks++; if (idle !== (m_outst() == 0)) begin n_fail++; $display("FAIL rnd_idle c=%0d: got %b", c, idle); end
            cycle();
        end
        drain();
    endtask

    initial begin
        idle_in();
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_reject();
        test_simultaneous();
        test_rid_err_x0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
